// File: rtl/fpnew_pkg.sv
// Slice of the shared FPnew package: format, rounding and operation encodings
// plus the format-geometry helpers used by the divsqrt front end.
package fpnew_pkg;

    localparam int unsigned NUM_FP_FORMATS = 5;
    localparam int unsigned FP_FORMAT_BITS = 3;

    typedef enum logic [FP_FORMAT_BITS-1:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef logic [0:NUM_FP_FORMATS-1] fmt_logic_t;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    // Widest enabled format sets the datapath width.
    function automatic int unsigned max_fp_width(fmt_logic_t cfg);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < NUM_FP_FORMATS; i++) begin
            if (cfg[i] && fp_width(fp_format_e'(3'(i))) > res) begin
                res = fp_width(fp_format_e'(3'(i)));
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fpnew_opnd_sanitize.sv
// Replaces an operand that is not NaN-boxed for the destination format with
// that format's canonical quiet NaN, boxed with ones above the format width.
module fpnew_opnd_sanitize
    import fpnew_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0]          operand_i,
    input  fp_format_e                dst_fmt_i,
    input  logic [NUM_FP_FORMATS-1:0] is_boxed_i,
    output logic [WIDTH-1:0]          operand_o
);

    int unsigned      fmt_w;
    int unsigned      man_w;
    logic             boxed;
    logic [WIDTH-1:0] qnan;

    // Bits [man_w-1 .. fmt_w-2] (mantissa MSB + exponent) set, sign clear.
    always_comb begin
        fmt_w = fp_width(dst_fmt_i);
        man_w = man_bits(dst_fmt_i);
        boxed = 1'b1;
        qnan  = '0;
        if (32'(dst_fmt_i) < NUM_FP_FORMATS) begin
            boxed = is_boxed_i[dst_fmt_i];
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            qnan[i] = (i >= fmt_w) || ((i + 1 >= man_w) && (i + 1 < fmt_w));
        end
        operand_o = boxed ? operand_i : qnan;
    end

endmodule

// File: rtl/fpnew_divsqrt_issue_queue.sv
// In-order issue queue in front of the iterative divsqrt unit: absorbs
// dispatch while the unit is busy and sanitizes unboxed operands on entry.
module fpnew_divsqrt_issue_queue
    import fpnew_pkg::*;
#(
    parameter fmt_logic_t  FpFmtConfig = '1,
    parameter int unsigned Depth       = 2,
    parameter int unsigned TagType     = 1,
    parameter int unsigned AuxType     = 1,
    localparam int unsigned WIDTH       = max_fp_width(FpFmtConfig),
    localparam int unsigned NUM_FORMATS = NUM_FP_FORMATS,
    localparam int unsigned LVL_W       = $clog2(Depth + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [1:0][WIDTH-1:0]           operands_i,
    input  logic [NUM_FORMATS-1:0][1:0]     is_boxed_i,
    input  roundmode_e                      rnd_mode_i,
    input  operation_e                      op_i,
    input  fp_format_e                      dst_fmt_i,
    input  logic [TagType:0]                tag_i,
    input  logic [AuxType:0]                aux_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic                            flush_i,
    output logic [1:0][WIDTH-1:0]           operands_o,
    output roundmode_e                      rnd_mode_o,
    output operation_e                      op_o,
    output fp_format_e                      dst_fmt_o,
    output logic [TagType:0]                tag_o,
    output logic [AuxType:0]                aux_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [LVL_W-1:0]                level_o,
    output logic                            busy_o
);

    localparam int unsigned PTR_W = (Depth > 1) ? $clog2(Depth) : 1;

    typedef struct packed {
        logic [1:0][WIDTH-1:0] operands;
        roundmode_e            rnd_mode;
        operation_e            op;
        fp_format_e            dst_fmt;
        logic [TagType:0]      tag;
        logic [AuxType:0]      aux;
    } entry_t;

    entry_t                         mem [Depth];
    entry_t                         wr_entry;
    entry_t                         head;
    logic [1:0][WIDTH-1:0]          sanitized;
    logic [1:0][NUM_FORMATS-1:0]    box_col;
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [LVL_W-1:0]               count;
    logic                           push;
    logic                           pop;

    function automatic logic [PTR_W-1:0] ptr_next(logic [PTR_W-1:0] p);
        return (p == PTR_W'(Depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Regroup box flags per operand for the sanitizers.
    always_comb begin
        box_col = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            for (int unsigned f = 0; f < NUM_FORMATS; f++) begin
                box_col[k][f] = is_boxed_i[f][k];
            end
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_sanitize
        fpnew_opnd_sanitize #(
            .WIDTH (WIDTH)
        ) i_sanitize (
            .operand_i  (operands_i[k]),
            .dst_fmt_i  (dst_fmt_i),
            .is_boxed_i (box_col[k]),
            .operand_o  (sanitized[k])
        );
    end

    assign wr_entry = '{
        operands: sanitized,
        rnd_mode: rnd_mode_i,
        op:       op_i,
        dst_fmt:  dst_fmt_i,
        tag:      tag_i,
        aux:      aux_i
    };

    assign in_ready_o  = (count != LVL_W'(Depth));
    assign out_valid_o = (count != '0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;

    // Pointer/occupancy state; reset and flush both empty the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop) begin
                count <= count + LVL_W'(1);
            end else if (pop && !push) begin
                count <= count - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign head       = out_valid_o ? mem[rd_ptr] : '0;
    assign operands_o = head.operands;
    assign rnd_mode_o = head.rnd_mode;
    assign op_o       = head.op;
    assign dst_fmt_o  = head.dst_fmt;
    assign tag_o      = head.tag;
    assign aux_o      = head.aux;
    assign level_o    = count;
    assign busy_o     = out_valid_o;

endmodule

// File: tb/tb_fpnew_divsqrt_issue_queue.sv
// Randomized bench for the divsqrt issue queue against a queue-based reference
// model, preceded by directed boxing, backpressure, wrap and flush scenarios.
module tb_fpnew_divsqrt_issue_queue;
    import fpnew_pkg::*;

    localparam int unsigned DEPTH = 3;

    typedef struct packed {
        logic [63:0] op0;
        logic [63:0] op1;
        logic [2:0]  rnd;
        logic [3:0]  op;
        logic [2:0]  fmt;
        logic [1:0]  tag;
        logic [1:0]  aux;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][63:0] operands;
    logic [4:0][1:0]  is_boxed;
    roundmode_e       rnd_mode;
    operation_e       op;
    fp_format_e       dst_fmt;
    logic [1:0]       tag;
    logic [1:0]       aux;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [1:0][63:0] operands_q;
    roundmode_e       rnd_mode_q;
    operation_e       op_q;
    fp_format_e       dst_fmt_q;
    logic [1:0]       tag_q;
    logic [1:0]       aux_q;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       level;
    logic             busy;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fpnew_divsqrt_issue_queue #(
        .FpFmtConfig ('1),
        .Depth       (DEPTH),
        .TagType     (1),
        .AuxType     (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .operands_i  (operands),
        .is_boxed_i  (is_boxed),
        .rnd_mode_i  (rnd_mode),
        .op_i        (op),
        .dst_fmt_i   (dst_fmt),
        .tag_i       (tag),
        .aux_i       (aux),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .flush_i     (flush),
        .operands_o  (operands_q),
        .rnd_mode_o  (rnd_mode_q),
        .op_o        (op_q),
        .dst_fmt_o   (dst_fmt_q),
        .tag_o       (tag_q),
        .aux_o       (aux_q),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .level_o     (level),
        .busy_o      (busy)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Canonical quiet NaN per format, boxed with ones above the format width.
    function automatic logic [63:0] canon(input logic [2:0] fmt, input logic [63:0] v,
                                          input logic boxed);
        logic [63:0] nan;
        int          w;
        if (boxed) return v;
        case (fmt)
            3'd0:    begin w = 32; nan = 64'h0000_0000_7FC0_0000; end
            3'd1:    begin w = 64; nan = 64'h7FF8_0000_0000_0000; end
            3'd2:    begin w = 16; nan = 64'h0000_0000_0000_7E00; end
            3'd3:    begin w = 8;  nan = 64'h0000_0000_0000_007E; end
            default: begin w = 16; nan = 64'h0000_0000_0000_7FC0; end
        endcase
        return (w == 64) ? nan : ((~64'd0 << w) | nan);
    endfunction

    task automatic check_outputs();
        exp_t h;
        h = (q.size() != 0) ? q[0] : '0;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready",  64'(in_ready),  64'(q.size() != DEPTH));
        chk("level",     64'(level),     64'(q.size()));
        chk("busy",      64'(busy),      64'(q.size() != 0));
        chk("opnd0",     operands_q[0],  h.op0);
        chk("opnd1",     operands_q[1],  h.op1);
        chk("rnd_mode",  64'(rnd_mode_q), 64'(h.rnd));
        chk("op",        64'(op_q),      64'(h.op));
        chk("dst_fmt",   64'(dst_fmt_q), 64'(h.fmt));
        chk("tag",       64'(tag_q),     64'(h.tag));
        chk("aux",       64'(aux_q),     64'(h.aux));
    endtask

    // Apply current inputs for one clock edge, advance the model, then check.
    task automatic cycle();
        bit   do_push;
        bit   do_pop;
        exp_t e;
        do_push = in_valid && (q.size() != DEPTH) && !flush && !rst;
        do_pop  = (q.size() != 0) && out_ready && !flush && !rst;
        e.op0 = canon(dst_fmt, operands[0], is_boxed[dst_fmt][0]);
        e.op1 = canon(dst_fmt, operands[1], is_boxed[dst_fmt][1]);
        e.rnd = rnd_mode;
        e.op  = op;
        e.fmt = dst_fmt;
        e.tag = tag;
        e.aux = aux;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drv(input bit v, input logic [63:0] o0, input logic [63:0] o1,
                       input logic [9:0] bx, input logic [2:0] fmt, input logic [1:0] tg,
                       input bit ordy, input bit fl, input bit r);
        in_valid    = v;
        operands[0] = o0;
        operands[1] = o1;
        is_boxed    = bx;
        dst_fmt     = fp_format_e'(fmt);
        tag         = tg;
        aux         = ~tg;
        op          = DIV;
        rnd_mode    = RNE;
        out_ready   = ordy;
        flush       = fl;
        rst         = r;
        cycle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operands = '0; is_boxed = '1; dst_fmt = FP32; tag = '0; aux = '0;
        op = DIV; rnd_mode = RNE;

        drv(0, 64'd0, 64'd0, '1, 3'd0, 2'd0, 0, 0, 1);
        drv(0, 64'd0, 64'd0, '1, 3'd0, 2'd0, 0, 0, 1);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        // Boxed FP32 passes through unchanged with one-cycle latency.
        drv(1, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_40000000, '1, 3'd0, 2'd1, 1, 0, 0);
        chk("boxed_op0",  operands_q[0], 64'hFFFFFFFF_3F800000);
        chk("boxed_op1",  operands_q[1], 64'hFFFFFFFF_40000000);
        chk("boxed_tag",  64'(tag_q), 64'd1);
        chk("boxed_lvl",  64'(level), 64'd1);
        drv(0, 64'd0, 64'd0, '1, 3'd0, 2'd0, 1, 0, 0);
        chk("boxed_drain", 64'(out_valid), 64'd0);

        drv(1, 64'h00000000_3F800000, 64'hFFFFFFFF_40000000, 10'h3FE, 3'd0, 2'd2, 1, 0, 0);
        chk("fp32_nan", operands_q[0], 64'hFFFFFFFF_7FC00000);
        chk("fp32_keep", operands_q[1], 64'hFFFFFFFF_40000000);
        drv(1, 64'h3FF00000_00000000, 64'h40000000_00000000, 10'h3F7, 3'd1, 2'd3, 1, 0, 0);
        chk("fp64_nan", operands_q[1], 64'h7FF80000_00000000);
        chk("fp64_keep", operands_q[0], 64'h3FF00000_00000000);
        drv(0, 64'd0, 64'd0, '1, 3'd0, 2'd0, 1, 0, 0);

        // Fill with downstream stalled; the fourth op is held upstream.
        drv(1, 64'd11, 64'd12, '1, 3'd1, 2'd1, 0, 0, 0);
        drv(1, 64'd21, 64'd22, '1, 3'd1, 2'd2, 0, 0, 0);
        drv(1, 64'd31, 64'd32, '1, 3'd1, 2'd3, 0, 0, 0);
        chk("full_ready", 64'(in_ready), 64'd0);
        drv(1, 64'd41, 64'd42, '1, 3'd1, 2'd0, 0, 0, 0);
        chk("full_head", 64'(tag_q), 64'd1);
        drv(1, 64'd41, 64'd42, '1, 3'd1, 2'd0, 1, 0, 0);
        chk("full_pop_head", 64'(tag_q), 64'd2);
        chk("full_pop_lvl", 64'(level), 64'd2);
        drv(1, 64'd41, 64'd42, '1, 3'd1, 2'd0, 1, 0, 0);
        chk("order_head", 64'(tag_q), 64'd3);
        for (int i = 0; i < 3; i++) drv(0, 64'd0, 64'd0, '1, 3'd0, 2'd0, 1, 0, 0);

        // Streaming: one in, one out per cycle across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            drv(1, {$urandom, $urandom}, {$urandom, $urandom}, '1, 3'd1, 2'(i), 1, 0, 0);
            chk("stream_lvl", 64'(level), 64'd1);
        end
        drv(0, 64'd0, 64'd0, '1, 3'd0, 2'd0, 1, 0, 0);

        // Flush with an input presented drops everything.
        drv(1, 64'd1, 64'd2, '1, 3'd0, 2'd1, 0, 0, 0);
        drv(1, 64'd3, 64'd4, '1, 3'd0, 2'd2, 0, 0, 0);
        drv(1, 64'd5, 64'd6, '1, 3'd0, 2'd3, 0, 1, 0);
        chk("flush_lvl",  64'(level), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        drv(0, 64'd0, 64'd0, '1, 3'd0, 2'd0, 1, 0, 0);
        chk("flush_gone", 64'(out_valid), 64'd0);

        drv(1, 64'd1, 64'd2, '1, 3'd0, 2'd1, 0, 0, 0);
        drv(1, 64'd3, 64'd4, '1, 3'd0, 2'd2, 0, 0, 0);
        drv(1, 64'd5, 64'd6, '1, 3'd0, 2'd3, 0, 0, 1);
        chk("rst_mid_lvl",  64'(level), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        drv(0, 64'd0, 64'd0, '1, 3'd0, 2'd0, 1, 0, 0);
        chk("rst_mid_gone", 64'(out_valid), 64'd0);

        for (int i = 0; i < 2000; i++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 99) < 4);
            rst         = ($urandom_range(0, 99) < 2);
            operands[0] = {$urandom, $urandom};
            operands[1] = {$urandom, $urandom};
            is_boxed    = 10'($urandom);
            dst_fmt     = fp_format_e'(3'($urandom_range(0, 4)));
            op          = operation_e'(4'($urandom_range(0, 14)));
            rnd_mode    = roundmode_e'(3'($urandom_range(0, 5)));
            tag         = 2'($urandom);
            aux         = 2'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
